// File: rtl/btn_event_if.sv
// btn_event_if: debounced button level and tick in, classified button events out.
interface btn_event_if #(
    parameter int CNT_W = 8
);
    logic             db_in;
    logic             m_tick;
    logic             press_p;
    logic             release_p;
    logic             click_p;
    logic             dclick_p;
    logic             long_p;
    logic [CNT_W-1:0] press_cnt;
    logic             busy;

    modport master (
        output db_in, m_tick,
        input  press_p, release_p, click_p, dclick_p, long_p, press_cnt, busy
    );

    modport slave (
        input  db_in, m_tick,
        output press_p, release_p, click_p, dclick_p, long_p, press_cnt, busy
    );
endinterface

// File: rtl/btn_event.sv
// btn_event: turns a debounced button level into press/release/click/double-click/long-press pulses.
// Every output is registered, so each pulse follows the clk edge that sampled its condition.
module btn_event #(
    parameter int LONG_TICKS   = 8,
    parameter int DCLICK_TICKS = 4,
    parameter int CNT_W        = 8
) (
    input logic        clk,
    input logic        rst,
    btn_event_if.slave bus
);
    typedef enum logic [2:0] {IDLE, PRESSED, LONG_HELD, WAIT2, PRESSED2} state_t;

    state_t           state, state_n;
    logic [7:0]       tcnt, tcnt_n;
    logic             press_n, release_n, click_n, dclick_n, long_n;
    logic             press_q, release_q, click_q, dclick_q, long_q, busy_q;
    logic [CNT_W-1:0] cnt_q;
    logic             long_exp, dclick_exp;

    assign long_exp   = bus.m_tick && tcnt == 8'(LONG_TICKS - 1);
    assign dclick_exp = bus.m_tick && tcnt == 8'(DCLICK_TICKS - 1);

    // A level change is tested before the tick expiry, so it wins a same-cycle tie.
    always_comb begin
        state_n   = state;
        press_n   = 1'b0;
        release_n = 1'b0;
        click_n   = 1'b0;
        dclick_n  = 1'b0;
        long_n    = 1'b0;
        case (state)
            IDLE: if (bus.db_in) begin
                state_n = PRESSED;
                press_n = 1'b1;
            end
            PRESSED: if (!bus.db_in) begin
                state_n   = WAIT2;
                release_n = 1'b1;
            end else if (long_exp) begin
                state_n = LONG_HELD;
                long_n  = 1'b1;
            end
            LONG_HELD: if (!bus.db_in) begin
                state_n   = IDLE;
                release_n = 1'b1;
            end
            WAIT2: if (bus.db_in) begin
                state_n = PRESSED2;
                press_n = 1'b1;
            end else if (dclick_exp) begin
                state_n = IDLE;
                click_n = 1'b1;
            end
            PRESSED2: if (!bus.db_in) begin
                state_n   = IDLE;
                release_n = 1'b1;
                dclick_n  = 1'b1;
            end else if (long_exp) begin
                state_n = LONG_HELD;
                long_n  = 1'b1;
            end
            default: state_n = IDLE;
        endcase
        tcnt_n = (state_n != state) ? 8'd0 : tcnt + 8'(bus.m_tick);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            tcnt      <= 8'd0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            click_q   <= 1'b0;
            dclick_q  <= 1'b0;
            long_q    <= 1'b0;
            busy_q    <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state     <= state_n;
            tcnt      <= tcnt_n;
            press_q   <= press_n;
            release_q <= release_n;
            click_q   <= click_n;
            dclick_q  <= dclick_n;
            long_q    <= long_n;
            busy_q    <= state_n != IDLE;
            cnt_q     <= (press_n && cnt_q != '1) ? cnt_q + CNT_W'(1) : cnt_q;
        end
    end

    assign bus.press_p   = press_q;
    assign bus.release_p = release_q;
    assign bus.click_p   = click_q;
    assign bus.dclick_p  = dclick_q;
    assign bus.long_p    = long_q;
    assign bus.busy      = busy_q;
    assign bus.press_cnt = cnt_q;
endmodule

// File: tb/tb_btn_event.sv
// tb_btn_event: queue scoreboard fed by a behavioural model, plus per-scenario event tallies.
module tb_btn_event;
    localparam int L = 4;
    localparam int D = 3;
    localparam int W = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    btn_event_if #(.CNT_W(W)) bus ();

    btn_event #(.LONG_TICKS(L), .DCLICK_TICKS(D), .CNT_W(W)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    int n_vec = 0;
    int n_err = 0;
    logic [9:0] sb[$];

    // behavioural model: 0 idle, 1 pressed, 2 long held, 3 wait for second press, 4 second press
    int m_st = 0;
    int m_t  = 0;
    int m_cnt = 0;
    int n_press, n_rel, n_click, n_dclick, n_long;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        n_press = 0; n_rel = 0; n_click = 0; n_dclick = 0; n_long = 0;
    endtask

    task automatic step(input logic d, input logic t, input logic r);
        logic [9:0] obs;
        int nxt;
        logic pp, rp, cp, dp, lp;
        @(negedge clk);
        obs = {bus.busy, bus.press_cnt, bus.long_p, bus.dclick_p, bus.click_p, bus.release_p, bus.press_p};
        if (sb.size() > 0) chk("outputs", 16'(obs), 16'(sb.pop_front()));
        chk("exclusive", 16'({bus.click_p, bus.dclick_p, bus.long_p} inside {3'b000, 3'b001, 3'b010, 3'b100}), 16'd1);
        chk("press_vs_release", 16'(bus.press_p & bus.release_p), 16'd0);
        n_press  += int'(bus.press_p);
        n_rel    += int'(bus.release_p);
        n_click  += int'(bus.click_p);
        n_dclick += int'(bus.dclick_p);
        n_long   += int'(bus.long_p);
        bus.db_in = d;
        bus.m_tick = t;
        rst = r;
        {pp, rp, cp, dp, lp} = 5'b0;
        if (r) begin
            m_st = 0; m_t = 0; m_cnt = 0;
        end else begin
            nxt = m_st;
            if (m_st == 0 && d) begin nxt = 1; pp = 1; end
            else if (m_st == 1) begin
                if (!d) begin nxt = 3; rp = 1; end
                else if (t && m_t == L - 1) begin nxt = 2; lp = 1; end
            end else if (m_st == 2 && !d) begin nxt = 0; rp = 1; end
            else if (m_st == 3) begin
                if (d) begin nxt = 4; pp = 1; end
                else if (t && m_t == D - 1) begin nxt = 0; cp = 1; end
            end else if (m_st == 4) begin
                if (!d) begin nxt = 0; rp = 1; dp = 1; end
                else if (t && m_t == L - 1) begin nxt = 2; lp = 1; end
            end
            m_t = (nxt != m_st) ? 0 : (m_t + int'(t)) % 256;
            if (pp && m_cnt < 15) m_cnt++;
            m_st = nxt;
        end
        sb.push_back({m_st != 0, 4'(m_cnt), lp, dp, cp, rp, pp});
    endtask

    task automatic ticks(input logic d, input int n);
        repeat (n) begin
            step(d, 1'b0, 1'b0);
            step(d, 1'b1, 1'b0);
        end
    endtask

    task automatic do_reset();
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        clr();
    endtask

    task automatic tally(input string tag, input int p, input int rl, input int c, input int dc, input int lg, input int cnt);
        chk({tag, ".press"}, 16'(n_press), 16'(p));
        chk({tag, ".release"}, 16'(n_rel), 16'(rl));
        chk({tag, ".click"}, 16'(n_click), 16'(c));
        chk({tag, ".dclick"}, 16'(n_dclick), 16'(dc));
        chk({tag, ".long"}, 16'(n_long), 16'(lg));
        chk({tag, ".press_cnt"}, 16'(bus.press_cnt), 16'(cnt));
        chk({tag, ".busy"}, 16'(bus.busy), 16'd0);
    endtask

    initial begin
        bus.db_in = 1'b0;
        bus.m_tick = 1'b0;
        do_reset();
        step(1'b0, 1'b0, 1'b0);
        chk("reset_state", 16'({bus.busy, bus.press_cnt, bus.long_p, bus.dclick_p, bus.click_p, bus.release_p, bus.press_p}), 16'd0);

        // single click
        do_reset();
        step(1'b1, 1'b0, 1'b0);
        ticks(1'b1, 2);
        step(1'b0, 1'b0, 1'b0);
        ticks(1'b0, 3);
        repeat (2) step(1'b0, 1'b0, 1'b0);
        tally("single", 1, 1, 1, 0, 0, 1);

        // double click
        do_reset();
        step(1'b1, 1'b0, 1'b0);
        ticks(1'b1, 1);
        step(1'b0, 1'b0, 1'b0);
        ticks(1'b0, 1);
        step(1'b1, 1'b0, 1'b0);
        ticks(1'b1, 1);
        repeat (6) step(1'b0, 1'b0, 1'b0);
        tally("double", 2, 2, 0, 1, 0, 2);

        // long press
        do_reset();
        step(1'b1, 1'b0, 1'b0);
        ticks(1'b1, 6);
        repeat (3) step(1'b0, 1'b0, 1'b0);
        tally("long", 1, 1, 0, 0, 1, 1);

        // counter saturation
        do_reset();
        repeat (20) begin
            step(1'b1, 1'b0, 1'b0);
            ticks(1'b1, 4);
            repeat (2) step(1'b0, 1'b0, 1'b0);
        end
        step(1'b0, 1'b0, 1'b0);
        tally("saturate", 20, 20, 0, 0, 20, 15);

        // press coinciding with the click-expiry tick
        do_reset();
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        ticks(1'b0, 2);
        step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        repeat (6) step(1'b0, 1'b0, 1'b0);
        tally("tiebreak", 2, 2, 0, 1, 0, 2);

        // reset in the middle of a press
        do_reset();
        step(1'b1, 1'b0, 1'b0);
        ticks(1'b1, 1);
        clr();
        step(1'b0, 1'b0, 1'b1);
        ticks(1'b0, 5);
        step(1'b0, 1'b0, 1'b0);
        tally("midreset", 0, 0, 0, 0, 0, 0);

        // button already down when reset releases
        do_reset();
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        chk("held_at_reset.press", 16'(n_press), 16'd1);
        chk("held_at_reset.busy", 16'(bus.busy), 16'd1);

        // random traffic, model-checked every cycle
        begin
            logic d = 1'b0;
            for (int i = 0; i < 600; i++) begin
                if ($urandom_range(5) == 0) d = ~d;
                step(d, 1'($urandom_range(2) == 0), 1'($urandom_range(80) == 0));
            end
        end
        step(1'b0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
